// File: rtl/ccip_c1_wr_sched.sv
// Round-robin arbiter sharing the CCI-P c1 write channel; routes responses by tag and drains on flush.
// Latency: accepted request appears on tx_c1 one cycle later; responses pulse wr_done one cycle later.
// Backpressure: no grant under c1_alm_full, at the outstanding limit, or outside RUN. Stats counters: C1_SCHED_STATS_EN.
module ccip_c1_wr_sched #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*42-1:0]  req_addr,
    input  logic [NUM_REQ*512-1:0] req_data,
    input  logic                   c1_alm_full,
    output logic                   tx_c1_valid,
    output logic [41:0]            tx_c1_addr,
    output logic [511:0]           tx_c1_data,
    output logic [15:0]            tx_c1_mdata,
    input  logic                   rsp_valid,
    input  logic [15:0]            rsp_mdata,
    output logic [NUM_REQ-1:0]     wr_done,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic [7:0]             outstanding,
    output logic                   err_underflow
`ifdef C1_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_grants,
    output logic [31:0]            stat_stalls
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_vld;
    int              cand;
    logic            can_issue;
    logic            xfer_vld;
    logic            rsp_dec;
    logic            rsp_tag_ok;
    logic [ID_W-1:0] rsp_tag;
    logic            unused_mdata;

    assign can_issue = (state == RUN) && !c1_alm_full && (outstanding < 8'(MAX_OUTST));

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_vld && req_valid[ID_W'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'(cand);
            end
        end
    end

    assign req_ready    = (can_issue && gnt_vld) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign xfer_vld     = |(req_valid & req_ready);
    assign rsp_tag      = rsp_mdata[ID_W-1:0];
    assign rsp_tag_ok   = rsp_valid && (int'(rsp_tag) < NUM_REQ);
    assign rsp_dec      = rsp_valid && (outstanding != 8'd0);
    // Upper mdata bits are echoed zeros and carry no routing information.
    assign unused_mdata = ^rsp_mdata[15:ID_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            tx_c1_valid <= 1'b0;
            tx_c1_addr  <= '0;
            tx_c1_data  <= '0;
            tx_c1_mdata <= '0;
        end else begin
            tx_c1_valid <= xfer_vld;
            if (xfer_vld) begin
                rr_ptr      <= gnt_idx;
                tx_c1_addr  <= req_addr[int'(gnt_idx)*42 +: 42];
                tx_c1_data  <= req_data[int'(gnt_idx)*512 +: 512];
                tx_c1_mdata <= 16'(gnt_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
            wr_done       <= '0;
        end else begin
            case ({xfer_vld, rsp_dec})
                2'b10:   outstanding <= outstanding + 8'd1;
                2'b01:   outstanding <= outstanding - 8'd1;
                default: outstanding <= outstanding;
            endcase
            if (rsp_valid && (outstanding == 8'd0))
                err_underflow <= 1'b1;
            wr_done <= rsp_tag_ok ? (NUM_REQ'(1) << rsp_tag) : '0;
        end
    end

    // Drain completion looks at the registered count, so DONE is at least one cycle after DRAIN entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (flush_req)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (outstanding == 8'd0) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= flush_req ? DRAIN : RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef C1_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            if (xfer_vld)
                stat_grants <= stat_grants + 32'd1;
            if ((|req_valid) && !xfer_vld && (stat_stalls != 32'hFFFF_FFFF))
                stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ccip_c1_wr_sched.sv
// Bench for ccip_c1_wr_sched: vector table for arbitration plus directed limit, flush, underflow and reset sequences.
module tb_ccip_c1_wr_sched;

    localparam int NR = 4;
    localparam int MO = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*42-1:0]  req_addr = '0;
    logic [NR*512-1:0] req_data = '0;
    logic            c1_alm_full = 1'b0;
    logic            tx_c1_valid;
    logic [41:0]     tx_c1_addr;
    logic [511:0]    tx_c1_data;
    logic [15:0]     tx_c1_mdata;
    logic            rsp_valid = 1'b0;
    logic [15:0]     rsp_mdata = '0;
    logic [NR-1:0]   wr_done;
    logic            flush_req = 1'b0;
    logic            flush_done;
    logic [7:0]      outstanding;
    logic            err_underflow;
`ifdef C1_SCHED_STATS_EN
    logic [31:0]     stat_grants;
    logic [31:0]     stat_stalls;
`endif

    ccip_c1_wr_sched #(.NUM_REQ(NR), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .c1_alm_full(c1_alm_full),
        .tx_c1_valid(tx_c1_valid), .tx_c1_addr(tx_c1_addr),
        .tx_c1_data(tx_c1_data), .tx_c1_mdata(tx_c1_mdata),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata),
        .wr_done(wr_done),
        .flush_req(flush_req), .flush_done(flush_done),
        .outstanding(outstanding), .err_underflow(err_underflow)
`ifdef C1_SCHED_STATS_EN
        , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rv;
        logic       af;
        logic [3:0] rdy;
    } vec_t;

    typedef struct {
        int          due;
        logic [41:0] addr;
        logic [511:0] data;
        logic [15:0] mdata;
    } exp_t;

    vec_t  tbl [19];
    exp_t  sb [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    mo      = 0;
    int    stim    = 0;
    logic  me      = 1'b0;
    logic [3:0] pend_wd = '0;
    string ctx     = "reset";

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [41:0] mk_addr(input int i, input int s);
        return 42'h200_0000_0000 | 42'(s * 16 + i);
    endfunction

    function automatic logic [511:0] mk_data(input int i, input int s);
        logic [31:0] w;
        w = 32'(s) ^ (32'(i) << 24) ^ 32'h5A00_0000;
        return {16{w}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%s]: got %0h expected %0h", nm, ctx, act, exp);
        end
    endtask

    // Scoreboard: each predicted write must appear exactly on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("tx_valid", 64'(tx_c1_valid), 64'd1);
            chk("tx_addr", 64'(tx_c1_addr), 64'(e.addr));
            chk("tx_mdata", 64'(tx_c1_mdata), 64'(e.mdata));
            n_tests++;
            if (tx_c1_data !== e.data) begin
                n_fail++;
                $display("FAIL tx_data [%s]: got low %h expected low %h", ctx, tx_c1_data[63:0], e.data[63:0]);
            end
        end else if (tx_c1_valid !== 1'b0) begin
            chk("tx_unexpected", 64'(tx_c1_valid), 64'd0);
        end
    end

    task automatic step(input logic [3:0] rv, input logic af, input logic fl,
                        input logic rsp, input logic [1:0] tag,
                        input logic [3:0] exp_rdy, input logic exp_fd);
        int idx;
        req_valid   = rv;
        c1_alm_full = af;
        flush_req   = fl;
        rsp_valid   = rsp;
        rsp_mdata   = {14'h0, tag};
        for (int i = 0; i < NR; i++) begin
            req_addr[42*i +: 42]   = mk_addr(i, stim);
            req_data[512*i +: 512] = mk_data(i, stim);
        end
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("outstanding", 64'(outstanding), 64'(mo));
        chk("wr_done", 64'(wr_done), 64'(pend_wd));
        chk("flush_done", 64'(flush_done), 64'(exp_fd));
        chk("err_underflow", 64'(err_underflow), 64'(me));
        idx = 0;
        for (int i = 0; i < NR; i++)
            if (exp_rdy[i]) idx = i;
        if (exp_rdy != 4'b0)
            sb.push_back('{cyc + 1, mk_addr(idx, stim), mk_data(idx, stim), 16'(idx)});
        pend_wd = rsp ? (4'b0001 << tag) : 4'b0000;
        if (rsp && mo == 0) me = 1'b1;
        mo = mo + ((exp_rdy != 4'b0) ? 1 : 0) - ((rsp && mo != 0) ? 1 : 0);
        stim++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0; c1_alm_full = 1'b0; flush_req = 1'b0;
        rsp_valid = 1'b0; rsp_mdata = '0;
        mo = 0; me = 1'b0; pend_wd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_tx_valid", 64'(tx_c1_valid), 64'd0);
        chk("rst_tx_mdata", 64'(tx_c1_mdata), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_wr_done", 64'(wr_done), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_err", 64'(err_underflow), 64'd0);
`ifdef C1_SCHED_STATS_EN
        chk("rst_stat_grants", 64'(stat_grants), 64'd0);
        chk("rst_stat_stalls", 64'(stat_stalls), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0001};
        for (int r = 5; r < 10; r++) tbl[r] = '{4'b0100, 1'b1, 4'b0000};
        tbl[10] = '{4'b0100, 1'b0, 4'b0100};
        tbl[11] = '{4'b0101, 1'b0, 4'b0001};
        tbl[12] = '{4'b0101, 1'b0, 4'b0100};
        tbl[13] = '{4'b0000, 1'b0, 4'b0000};
        tbl[14] = '{4'b1010, 1'b0, 4'b1000};
        tbl[15] = '{4'b1010, 1'b0, 4'b0010};
        tbl[16] = '{4'b0010, 1'b0, 4'b0010};
        tbl[17] = '{4'b1010, 1'b1, 4'b0000};
        tbl[18] = '{4'b1010, 1'b0, 4'b1000};

        #1;
        apply_reset();

        // Arbitration order, alm_full gating, sparse requesters.
        for (int r = 0; r < 19; r++) begin
            ctx = $sformatf("vec%0d", r);
            step(tbl[r].rv, tbl[r].af, 1'b0, 1'b0, 2'd0, tbl[r].rdy, 1'b0);
        end

        // Response routing and simultaneous issue + response.
        ctx = "rsp_route";
        step(4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0);
        ctx = "issue_and_rsp";
        step(4'b0001, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0001, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);

        // Fill to the outstanding limit, then one response frees exactly one slot.
        ctx = "fill";
        for (int k = 0; k < 24; k++)
            step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, (mo < MO) ? 4'b0001 : 4'b0000, 1'b0);
        ctx = "limit_rsp_same_cycle";
        step(4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
        ctx = "limit_unblock";
        step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0);
        ctx = "limit_reblock";
        step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);

        ctx = "drain_to_3";
        for (int k = 0; k < 29; k++)
            step(4'b0000, 1'b0, 1'b0, 1'b1, 2'(k % 4), 4'b0000, 1'b0);

        // Flush: same-cycle grant honoured, then responses spaced 10 cycles.
        ctx = "flush_grant";
        step(4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b0);
        for (int k = 0; k < 4; k++) begin
            ctx = $sformatf("drain_rsp%0d", k);
            repeat (9) step(4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
            step(4'b0010, 1'b0, 1'b1, 1'b1, 2'(k), 4'b0000, 1'b0);
        end
        ctx = "drain_zero";
        step(4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
        ctx = "flush_done";
        step(4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
        ctx = "resume";
        step(4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0);

        // Re-flush straight out of DONE.
        ctx = "reflush";
        step(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1);
        step(4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
        step(4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);

        ctx = "underflow";
        step(4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);

        // Reset in the middle of traffic restores pointer and clears sticky error.
        ctx = "pre_reset";
        step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        ctx = "mid_reset";
        apply_reset();

        ctx = "post_reset_rr";
        for (int k = 0; k < 8; k++)
            step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001 << (k % 4), 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
`ifdef C1_SCHED_STATS_EN
        chk("stat_grants", 64'(stat_grants), 64'd8);
`endif
        ctx = "stall_count";
        repeat (4) step(4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
`ifdef C1_SCHED_STATS_EN
        chk("stat_stalls", 64'(stat_stalls), 64'd4);
        chk("stat_grants_hold", 64'(stat_grants), 64'd8);
`endif

        ctx = "end";
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
